// File: rtl/gemm_pkg.sv
// gemm_pkg: shared state encoding and address-width helper for the GEMM sequencer
package gemm_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  function automatic int unsigned aw(input int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gemm_loop_cnt.sv
// gemm_loop_cnt: i/j/k nested wrap counter advancing on each accepted beat
module gemm_loop_cnt import gemm_pkg::*; #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 4,
  parameter int unsigned K = 4,
  localparam int unsigned IW = aw(M),
  localparam int unsigned JW = aw(N),
  localparam int unsigned KW = aw(K)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          clr,
  input  logic          adv,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [KW-1:0] k,
  output logic          first_k,
  output logic          last_k,
  output logic          last_all
);
  logic last_j, last_i;
  assign first_k  = k == '0;
  assign last_k   = k == KW'(K - 1);
  assign last_j   = j == JW'(N - 1);
  assign last_i   = i == IW'(M - 1);
  assign last_all = last_i && last_j && last_k;
  always_ff @(posedge iclk)
    if (!irst || clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (adv) begin
      k <= last_k ? '0 : k + 1'b1;
      if (last_k) j <= last_j ? '0 : j + 1'b1;
      if (last_k && last_j) i <= last_i ? '0 : i + 1'b1;
    end
endmodule

// File: rtl/gemm_seq_ctrl.sv
// gemm_seq_ctrl: GEMM loop-nest sequencer with result credits and in-order write-back
module gemm_seq_ctrl import gemm_pkg::*; #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MATRIX_HEIGHT = 4,
  parameter int unsigned MATRIX_WIDTH  = 4,
  parameter int unsigned MATRIX_ADJUST = 4,
  parameter int unsigned MAX_OUT       = 4,
  localparam int unsigned AAW = aw(MATRIX_HEIGHT * MATRIX_ADJUST),
  localparam int unsigned BAW = aw(MATRIX_ADJUST * MATRIX_WIDTH),
  localparam int unsigned CAW = aw(MATRIX_HEIGHT * MATRIX_WIDTH)
) (
  input  logic           iclk,
  input  logic           irst,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           op_valid,
  input  logic           op_ready,
  output logic [AAW-1:0] a_addr,
  output logic [BAW-1:0] b_addr,
  output logic [CAW-1:0] c_addr,
  output logic           mac_clr,
  output logic           mac_last,
  input  logic           res_valid,
  output logic           wr_en,
  output logic [CAW-1:0] wr_addr
);
  localparam int unsigned M  = MATRIX_HEIGHT;
  localparam int unsigned N  = MATRIX_WIDTH;
  localparam int unsigned K  = MATRIX_ADJUST;
  localparam int unsigned CW = aw(MAX_OUT + 1);
  localparam int unsigned WW = aw(M * N + 1);
  state_t state, state_n;
  logic [CW-1:0] credits_used;
  logic [WW-1:0] wr_cnt;
  logic [aw(M)-1:0] i;
  logic [aw(N)-1:0] j;
  logic [aw(K)-1:0] k;
  logic first_k, last_k, last_all, xfer, run, accept, fin;
  gemm_loop_cnt #(.M(M), .N(N), .K(K)) u_loop (
    .iclk(iclk), .irst(irst), .clr(abort), .adv(xfer),
    .i(i), .j(j), .k(k), .first_k(first_k), .last_k(last_k), .last_all(last_all)
  );
  assign run      = state == ISSUE || state == DRAIN;
  assign busy     = run;
  assign done     = state == DONE;
  assign op_valid = state == ISSUE && !(first_k && credits_used == CW'(MAX_OUT));
  assign xfer     = op_valid && op_ready;
  assign wr_en    = res_valid && run && credits_used != '0;
  assign accept   = state == IDLE && start && !abort;
  assign fin      = wr_cnt + WW'(wr_en) == WW'(M * N);
  assign a_addr   = AAW'(i) * AAW'(K) + AAW'(k);
  assign b_addr   = BAW'(k) * BAW'(N) + BAW'(j);
  assign c_addr   = CAW'(i) * CAW'(N) + CAW'(j);
  assign mac_clr  = first_k;
  assign mac_last = last_k;
  assign wr_addr  = CAW'(wr_cnt);
  always_comb begin
    state_n = abort ? IDLE :
              state == IDLE  ? (start ? ISSUE : IDLE) :
              state == ISSUE ? (xfer && last_all ? DRAIN : ISSUE) :
              state == DRAIN ? (fin ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge iclk)
    if (!irst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge iclk)
    if (!irst || abort) begin
      credits_used <= '0;
      wr_cnt       <= '0;
    end else begin
      credits_used <= credits_used + CW'(xfer && last_k) - CW'(wr_en);
      wr_cnt       <= accept ? '0 : wr_cnt + WW'(wr_en);
    end
  always_ff @(posedge iclk)
    if (!irst) err <= 1'b0;
    else if (res_valid && !wr_en) err <= 1'b1;
    else if (accept) err <= 1'b0;
endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// tb_gemm_seq_ctrl: directed scoreboard bench for the GEMM sequencer
module tb_gemm_seq_ctrl;
  localparam int M = 4, N = 4, K = 4, MO = 2;
  logic iclk = 0, irst = 0, start = 0, abort = 0, op_ready = 0, res_valid = 0;
  logic busy, done, err, op_valid, mac_clr, mac_last, wr_en;
  logic [3:0] a_addr, b_addr, c_addr, wr_addr;
  int checks = 0, failures = 0;
  int cyc = 0, lat = 3, b = 0, cnt = 0, nwr = 0, stalls = 0;
  bit n_irst = 0, n_start = 0, n_abort = 0;
  bit rand_ready = 0, force_rv = 0, run = 0, dph = 0, errm = 0;
  int exp_q[$];
  int due_q[$];
  always #5 iclk = ~iclk;
  gemm_seq_ctrl #(
    .DATA_WIDTH(32), .MATRIX_HEIGHT(M), .MATRIX_WIDTH(N), .MATRIX_ADJUST(K), .MAX_OUT(MO)
  ) dut (
    .iclk(iclk), .irst(irst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err(err), .op_valid(op_valid), .op_ready(op_ready), .a_addr(a_addr), .b_addr(b_addr),
    .c_addr(c_addr), .mac_clr(mac_clr), .mac_last(mac_last), .res_valid(res_valid),
    .wr_en(wr_en), .wr_addr(wr_addr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic observe();
    bit xf, ew, acc, lw;
    chk("busy", busy, run);
    chk("done", done, dph);
    chk("err", err, errm);
    chk("op_valid", op_valid, run && b < M*N*K && !(b % K == 0 && cnt >= MO));
    ew = res_valid && run && cnt > 0;
    chk("wr_en", wr_en, ew);
    if (ew) begin
      chk("wr_addr", wr_addr, exp_q.pop_front());
      nwr++;
    end
    if (res_valid && !force_rv && due_q.size() > 0) void'(due_q.pop_front());
    if (run && b < M*N*K && op_valid !== 1'b1) stalls++;
    xf = op_valid === 1'b1 && op_ready;
    if (op_valid === 1'b1) begin
      chk("a_addr", a_addr, (b / (N*K)) * K + b % K);
      chk("b_addr", b_addr, (b % K) * N + (b / K) % N);
      chk("c_addr", c_addr, (b / (N*K)) * N + (b / K) % N);
      chk("mac_clr", mac_clr, b % K == 0);
      chk("mac_last", mac_last, b % K == K - 1);
    end
    if (xf && b % K == K - 1) begin
      exp_q.push_back((b / (N*K)) * N + (b / K) % N);
      due_q.push_back((due_q.size() > 0 && due_q[$] >= cyc + lat) ? due_q[$] + 1 : cyc + lat);
      cnt++;
    end
    if (ew) cnt--;
    if (xf) b++;
    lw = ew && nwr == M*N;
    acc = start && !run && !dph && !abort;
    errm = (res_valid && !ew) ? 1'b1 : acc ? 1'b0 : errm;
    run = acc ? 1'b1 : lw ? 1'b0 : run;
    dph = lw;
    if (acc) begin
      b = 0;
      nwr = 0;
    end
    if (abort || !irst) begin
      run = 0; dph = 0; b = 0; cnt = 0; nwr = 0;
      exp_q.delete();
      due_q.delete();
      if (!irst) errm = 0;
    end
  endtask
  task automatic step();
    @(posedge iclk);
    #1;
    cyc++;
    irst = n_irst;
    start = n_start;
    abort = n_abort;
    op_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    res_valid = force_rv || (due_q.size() > 0 && due_q[0] <= cyc);
    @(negedge iclk);
    observe();
  endtask
  task automatic run_to_done(input int lim);
    int n = 0;
    while (!dph && n < lim) begin
      step();
      n++;
    end
    chk("finished", dph, 1);
    chk("beats", b, M*N*K);
    chk("writes", nwr, M*N);
    chk("sb_empty", exp_q.size(), 0);
    step();
  endtask
  initial begin
    repeat (2) @(posedge iclk);
    step();
    chk("rst_op_valid", op_valid, 0);
    chk("rst_wr_en", wr_en, 0);
    n_irst = 1;
    step();
    lat = 3;
    n_start = 1; step(); n_start = 0;
    run_to_done(1000);
    step();
    rand_ready = 1;
    n_start = 1; step(); n_start = 0;
    run_to_done(2000);
    rand_ready = 0;
    lat = 10;
    stalls = 0;
    n_start = 1; step(); n_start = 0;
    run_to_done(3000);
    chk("credit_stall_seen", stalls > 0, 1);
    lat = 3;
    n_start = 1; step(); n_start = 0;
    for (int n = 0; n < 500 && b != 30; n++) step();
    chk("reach_beat30", b, 30);
    n_abort = 1; step(); n_abort = 0;
    step();
    chk("abort_idle", busy, 0);
    chk("abort_no_done", done, 0);
    n_start = 1; step(); n_start = 0;
    run_to_done(1000);
    force_rv = 1; step(); force_rv = 0;
    step();
    chk("idle_res_err", err, 1);
    n_start = 1; step(); n_start = 0;
    step();
    chk("start_clears_err", err, 0);
    run_to_done(1000);
    n_start = 1; step();
    run_to_done(1000);
    step();
    n_start = 0;
    step();
    chk("restart_busy", busy, 1);
    run_to_done(1000);
    n_start = 1; step(); n_start = 0;
    repeat (20) step();
    n_irst = 0; step(); n_irst = 1;
    step();
    chk("midrun_rst_idle", busy, 0);
    n_start = 1; step(); n_start = 0;
    run_to_done(1000);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
